rr_ring_arbiter: RTL

Round-robin arbiter that shares one resource among N requesters. Priority is held in a one-hot ring pointer that rotates one position past each served requester. Grants are registered and held until the owner releases or a hold limit expires. It sits in front of any shared datapath, such as a bus port, memory bank or shift-register chain, and sequences access to it.

---
 rtl/rr_ring_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot ring priority pointer, registered grants,
// a per-ownership hold limit and a mandatory one-cycle turnaround between grants.
module rr_ring_arbiter #(
   parameter int unsigned N        = 4,
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned IDW      = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] owner_id,
   output logic           busy,
   output logic           preempt,
   output logic [N-1:0]   prio
);

   // Unlimited hold still needs a finite counter; it simply saturates.
   localparam int unsigned HCW    = (MAX_HOLD == 0) ? 8 : $clog2(MAX_HOLD + 1);
   localparam int unsigned HC_SAT = (MAX_HOLD == 0) ? ((1 << HCW) - 1) : MAX_HOLD;

   typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

   state_t           state_q;
   logic [N-1:0]     gnt_q;
   logic [N-1:0]     prio_q;
   logic [IDW-1:0]   owner_q;
   logic             busy_q;
   logic             preempt_q;
   logic [HCW-1:0]   hold_cnt_q;

   logic [N-1:0]     pick_c;
   logic [IDW-1:0]   pick_id_c;

   // First requester at or circularly above the priority pointer.
   always_comb begin : pick
      int unsigned base;
      int unsigned k;
      logic        found;
      base      = 0;
      k         = 0;
      found     = 1'b0;
      pick_c    = '0;
      pick_id_c = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (prio_q[IDW'(i)]) base = i;
      end
      for (int unsigned i = 0; i < N; i++) begin
         k = (base + i) % N;
         if (!found && req[IDW'(k)]) begin
            found             = 1'b1;
            pick_c[IDW'(k)]   = 1'b1;
            pick_id_c         = IDW'(k);
         end
      end
   end

   // Arbitration FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         owner_q    <= '0;
         busy_q     <= 1'b0;
         preempt_q  <= 1'b0;
         hold_cnt_q <= '0;
         prio_q     <= N'(1);
      end else begin
         preempt_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (en && (|req)) begin
                  gnt_q      <= pick_c;
                  owner_q    <= pick_id_c;
                  busy_q     <= 1'b1;
                  hold_cnt_q <= HCW'(1);
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               if (!req[owner_q] ||
                   ((MAX_HOLD != 0) && (hold_cnt_q == HCW'(MAX_HOLD)))) begin
                  // Served requester drops to lowest priority.
                  preempt_q <= req[owner_q];
                  prio_q    <= {gnt_q[N-2:0], gnt_q[N-1]};
                  gnt_q     <= '0;
                  owner_q   <= '0;
                  busy_q    <= 1'b0;
                  state_q   <= TURN;
               end else if (hold_cnt_q != HCW'(HC_SAT)) begin
                  hold_cnt_q <= hold_cnt_q + HCW'(1);
               end
            end
            TURN: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt      = gnt_q;
   assign owner_id = owner_q;
   assign busy     = busy_q;
   assign preempt  = preempt_q;
   assign prio     = prio_q;

endmodule
